// File: rtl/prog_rom.sv
// rtl/prog_rom.sv - writable program store with word-serial load port
// Answers core fetches combinationally and holds the core in reset while reloading.
module prog_rom #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4,
  parameter logic [DATA_W*(2**ADDR_W)-1:0] INIT = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_value,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              busy,
  output logic              done,
  output logic              core_rstn
);

  localparam int DEPTH = 2**ADDR_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              xfer;

  assign load_ready = (state == ST_LOAD);
  assign busy       = (state == ST_LOAD) || (state == ST_FINISH);
  assign done       = (state == ST_FINISH);
  assign xfer       = load_valid && load_ready;
  assign rom_value  = busy ? '0 : mem[rom_addr];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= INIT[i*DATA_W +: DATA_W];
      end
      state     <= ST_IDLE;
      idx       <= '0;
      core_rstn <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          core_rstn <= !load_start;
          if (load_start) begin
            state <= ST_LOAD;
            idx   <= '0;
          end
        end
        ST_LOAD: begin
          core_rstn <= 1'b0;
          if (xfer) begin
            mem[idx] <= load_data;
            idx      <= idx + 1'b1;
          end
          // Abort wins over completion, even when it lands on the last word.
          if (load_abort) begin
            state <= ST_IDLE;
          end else if (xfer && idx == '1) begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          core_rstn <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          core_rstn <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_rom.sv
// tb/tb_prog_rom.sv - directed self-checking bench for prog_rom
module tb_prog_rom;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] rom_addr;
  logic [3:0] rom_value;
  logic       load_start;
  logic       load_abort;
  logic       load_valid;
  logic [3:0] load_data;
  logic       load_ready;
  logic       busy;
  logic       done;
  logic       core_rstn;

  int checks = 0;
  int errors = 0;

  int s_dones, s_done_at, s_last_xfer, s_lows, s_zbad, s_idle_at, s_end;

  prog_rom #(.ADDR_W(2), .DATA_W(4), .INIT(16'hB3A1)) dut (
    .clock      (clock),
    .reset      (reset),
    .rom_addr   (rom_addr),
    .rom_value  (rom_value),
    .load_start (load_start),
    .load_abort (load_abort),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .busy       (busy),
    .done       (done),
    .core_rstn  (core_rstn)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  // Runs one session from load_start until core_rstn rises, collecting observations.
  task automatic run_session(input logic [15:0] data, input logic [7:0] vpat, input int plen,
                             input int abort_at, input bit abort_valid, input bit start_pulse);
    int n;
    int xfers;
    bit xfer_now;
    bit aborted;
    s_dones = 0; s_done_at = -1; s_last_xfer = -1; s_lows = 0; s_zbad = 0;
    s_idle_at = -1; s_end = -1;
    rom_addr = 2'd1;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    n = 0; xfers = 0; aborted = 1'b0;
    while (n < 40) begin
      if (!core_rstn) s_lows++;
      if (done) begin s_dones++; s_done_at = n; end
      if (busy && rom_value !== 4'h0) s_zbad++;
      if (!busy && s_idle_at < 0) s_idle_at = n;
      if (core_rstn) begin s_end = n; break; end
      load_start = start_pulse && busy;
      if (!aborted && busy && xfers == abort_at) begin
        load_abort = 1'b1;
        aborted    = 1'b1;
        load_valid = abort_valid;
      end else begin
        load_abort = 1'b0;
        load_valid = busy && (xfers < 4) && vpat[n % plen];
      end
      load_data = (xfers < 4) ? data[xfers*4 +: 4] : 4'h0;
      xfer_now  = load_valid && load_ready;
      step();
      n++;
      if (xfer_now) begin xfers++; s_last_xfer = n; end
    end
    load_start = 1'b0; load_abort = 1'b0; load_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    exp = 16'hB3A1;
    reset = 1'b1;
    step();
    step();
    checks++; if (core_rstn !== 1'b0) begin errors++; $display("FAIL reset_core_rstn: got %b expected 0", core_rstn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready: got %b expected 0", load_ready); end
    for (int a = 0; a < 4; a++) begin
      rom_addr = 2'(a);
      #1;
      checks++;
      if (rom_value !== exp[a*4 +: 4]) begin
        errors++; $display("FAIL reset_readback[%0d]: got %h expected %h", a, rom_value, exp[a*4 +: 4]);
      end
    end
    reset = 1'b0;
    step();
    checks++; if (core_rstn !== 1'b1) begin errors++; $display("FAIL reset_release_core_rstn: got %b expected 1", core_rstn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_full_load(input string tag);
    logic [15:0] exp;
    exp = 16'h2F49;
    run_session(16'h2F49, 8'hFF, 8, -1, 1'b0, 1'b0);
    checks++; if (s_end !== 6) begin errors++; $display("FAIL %s_core_rstn_rise: got %0d expected 6", tag, s_end); end
    checks++; if (s_dones !== 1) begin errors++; $display("FAIL %s_done_count: got %0d expected 1", tag, s_dones); end
    checks++; if (s_last_xfer !== 4) begin errors++; $display("FAIL %s_last_xfer: got %0d expected 4", tag, s_last_xfer); end
    checks++; if (s_done_at !== 4) begin errors++; $display("FAIL %s_done_cycle: got %0d expected 4", tag, s_done_at); end
    checks++; if (s_lows !== 6) begin errors++; $display("FAIL %s_core_rstn_low: got %0d expected 6", tag, s_lows); end
    checks++; if (s_zbad !== 0) begin errors++; $display("FAIL %s_busy_forced_zero: got %0d expected 0", tag, s_zbad); end
    for (int a = 0; a < 4; a++) begin
      rom_addr = 2'(a);
      #1;
      checks++;
      if (rom_value !== exp[a*4 +: 4]) begin
        errors++; $display("FAIL %s_readback[%0d]: got %h expected %h", tag, a, rom_value, exp[a*4 +: 4]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [15:0] exp;
    exp = 16'h8C37;
    run_session(16'h8C37, 8'h59, 7, -1, 1'b0, 1'b0);
    checks++; if (s_end !== 9) begin errors++; $display("FAIL gaps_core_rstn_rise: got %0d expected 9", s_end); end
    checks++; if (s_last_xfer !== 7) begin errors++; $display("FAIL gaps_last_xfer: got %0d expected 7", s_last_xfer); end
    checks++; if (s_dones !== 1) begin errors++; $display("FAIL gaps_done_count: got %0d expected 1", s_dones); end
    checks++; if (s_done_at !== 7) begin errors++; $display("FAIL gaps_done_cycle: got %0d expected 7", s_done_at); end
    checks++; if (s_lows !== 9) begin errors++; $display("FAIL gaps_core_rstn_low: got %0d expected 9", s_lows); end
    checks++; if (s_zbad !== 0) begin errors++; $display("FAIL gaps_busy_forced_zero: got %0d expected 0", s_zbad); end
    for (int a = 0; a < 4; a++) begin
      rom_addr = 2'(a);
      #1;
      checks++;
      if (rom_value !== exp[a*4 +: 4]) begin
        errors++; $display("FAIL gaps_readback[%0d]: got %h expected %h", a, rom_value, exp[a*4 +: 4]);
      end
    end
  endtask

  task automatic test_abort();
    logic [15:0] exp;
    exp = 16'hB365;
    do_reset();
    run_session(16'h0065, 8'hFF, 8, 2, 1'b0, 1'b0);
    checks++; if (s_dones !== 0) begin errors++; $display("FAIL abort_done_count: got %0d expected 0", s_dones); end
    checks++; if (s_idle_at !== 3) begin errors++; $display("FAIL abort_idle_cycle: got %0d expected 3", s_idle_at); end
    checks++; if (s_end !== 4) begin errors++; $display("FAIL abort_core_rstn_rise: got %0d expected 4", s_end); end
    for (int a = 0; a < 4; a++) begin
      rom_addr = 2'(a);
      #1;
      checks++;
      if (rom_value !== exp[a*4 +: 4]) begin
        errors++; $display("FAIL abort_readback[%0d]: got %h expected %h", a, rom_value, exp[a*4 +: 4]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] exp;
    exp = 16'h4321;
    run_session(16'h4321, 8'hFF, 8, -1, 1'b0, 1'b1);
    checks++; if (s_dones !== 1) begin errors++; $display("FAIL start_ignored_done_count: got %0d expected 1", s_dones); end
    checks++; if (s_done_at !== 4) begin errors++; $display("FAIL start_ignored_done_cycle: got %0d expected 4", s_done_at); end
    checks++; if (s_end !== 6) begin errors++; $display("FAIL start_ignored_core_rstn_rise: got %0d expected 6", s_end); end
    for (int a = 0; a < 4; a++) begin
      rom_addr = 2'(a);
      #1;
      checks++;
      if (rom_value !== exp[a*4 +: 4]) begin
        errors++; $display("FAIL start_ignored_readback[%0d]: got %h expected %h", a, rom_value, exp[a*4 +: 4]);
      end
    end
  endtask

  task automatic test_abort_last();
    logic [15:0] exp;
    exp = 16'hA987;
    run_session(16'hA987, 8'hFF, 8, 3, 1'b1, 1'b0);
    checks++; if (s_dones !== 0) begin errors++; $display("FAIL abort_last_done_count: got %0d expected 0", s_dones); end
    checks++; if (s_last_xfer !== 4) begin errors++; $display("FAIL abort_last_xfer: got %0d expected 4", s_last_xfer); end
    checks++; if (s_idle_at !== 4) begin errors++; $display("FAIL abort_last_idle_cycle: got %0d expected 4", s_idle_at); end
    checks++; if (s_end !== 5) begin errors++; $display("FAIL abort_last_core_rstn_rise: got %0d expected 5", s_end); end
    for (int a = 0; a < 4; a++) begin
      rom_addr = 2'(a);
      #1;
      checks++;
      if (rom_value !== exp[a*4 +: 4]) begin
        errors++; $display("FAIL abort_last_readback[%0d]: got %h expected %h", a, rom_value, exp[a*4 +: 4]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] exp;
    exp = 16'hB3A1;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      load_data = 4'(12 + k);
      step();
    end
    load_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL midreset_load_ready: got %b expected 0", load_ready); end
    checks++; if (core_rstn !== 1'b0) begin errors++; $display("FAIL midreset_core_rstn: got %b expected 0", core_rstn); end
    for (int a = 0; a < 4; a++) begin
      rom_addr = 2'(a);
      #1;
      checks++;
      if (rom_value !== exp[a*4 +: 4]) begin
        errors++; $display("FAIL midreset_readback[%0d]: got %h expected %h", a, rom_value, exp[a*4 +: 4]);
      end
    end
    reset = 1'b0;
    step();
    checks++; if (core_rstn !== 1'b1) begin errors++; $display("FAIL midreset_release_core_rstn: got %b expected 1", core_rstn); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_release_done: got %b expected 0", done); end
    test_full_load("after_midreset");
  endtask

  initial begin
    reset      = 1'b1;
    rom_addr   = 2'd0;
    load_start = 1'b0;
    load_abort = 1'b0;
    load_valid = 1'b0;
    load_data  = 4'h0;
    test_reset();
    test_full_load("full");
    test_gaps();
    test_abort();
    test_start_ignored();
    test_abort_last();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
